clock: RTL and testbench
========================

CLOCK -- requirements
Module: clock

Interface
REQ-001 Parameter HALF_PERIOD, default 5 (ns, timescale 1 ns / 100 ps), high/low phase duration; legal range 1..1_000_000.
REQ-002 Parameter START_DELAY, default 0 (ns), delay from time 0 before the first toggle is scheduled.
REQ-003 Parameter INIT_LEVEL, default 1'b0, clk level at time 0 and after reset.
REQ-004 Parameter DIV_N, default 2, even divide ratio for clk_div; legal range 2..256.
REQ-005 Port clk, output, 1, generated free-running clock; always first positional port.
REQ-006 Port rst, input, 1, asynchronous active-high reset; unconnected (z/x) SHALL be treated as deasserted.
REQ-007 Port en, input, 1, run enable; unconnected (z/x) SHALL be treated as 1.
REQ-008 Port clk_div, output, 1, clk divided by DIV_N at 50 % duty.
REQ-009 Port cycle_count, output, 64, count of clk rising edges since the last reset.
REQ-010 Reset rst, asynchronous, active-high; clock clk.
REQ-011 A one-port positional instance `clock u(clk)` SHALL compile and run with all defaults.

Function
REQ-012 At time 0: clk=INIT_LEVEL, clk_div=0, cycle_count=0.
REQ-013 With defaults, clk SHALL toggle every HALF_PERIOD: first rising edge at 5 ns, then 15, 25, ...; period 10 ns, 50 % duty.
REQ-014 First toggle SHALL occur at START_DELAY+HALF_PERIOD.
REQ-015 cycle_count SHALL increment by 1 in the same time step as every clk rising edge; wraps 2^64-1 -> 0.
REQ-016 clk_div SHALL toggle on every (DIV_N/2)-th clk rising edge, counted from reset release.
REQ-017 en=0: clk SHALL hold its current level, no edges, counters frozen; en 0->1 SHALL resume with a full HALF_PERIOD before the next toggle (no runt pulse).
REQ-018 en toggling mid-phase SHALL never produce a phase shorter than HALF_PERIOD.
REQ-019 Model is simulation-only (delay-based); it SHALL not be instantiated in synthesizable top levels.

Reset
REQ-020 rst rising SHALL immediately (zero delay) force clk=INIT_LEVEL, clk_div=0, cycle_count=0 and cancel any pending toggle.
REQ-021 While rst=1, outputs SHALL hold reset values.
REQ-022 rst falling SHALL restart timing: first toggle exactly HALF_PERIOD later (START_DELAY not reapplied).
REQ-023 rst has priority over en; reset asserted during en=0 SHALL still apply reset values.
REQ-024 A rst pulse shorter than one timestep SHALL still reset all outputs.

Structure
REQ-025 Default timing constants (DEFAULT_HALF_PERIOD=5, DEFAULT_DIV_N=2) SHALL live in the shared package sim_clk_pkg; no typedefs needed.
REQ-026 Divider logic SHALL be a sub-module clock_divider (inputs clk, rst, parameter DIV_N; output clk_div); edge generation and cycle counter stay in clock.
REQ-027 Parameter legality SHALL be checked at elaboration with a fatal message on violation.

Verification
REQ-028 Defaults, no rst/en connected, run 50 ns -> rising edges at 5,15,25,35,45 ns; cycle_count=5 at 46 ns.
REQ-029 rst pulse 1 at 32 ns for 3 ns -> at 32 ns clk=0, cycle_count=0; next rising edge at 40 ns.
REQ-030 en=0 at 12 ns (clk high), en=1 at 30 ns -> clk stays 1 through 12..35 ns, falls at 35 ns, rises at 40 ns.
REQ-031 DIV_N=4, defaults otherwise -> clk_div rises at 15 ns, falls at 35 ns, period 40 ns.
REQ-032 HALF_PERIOD=2, START_DELAY=7, INIT_LEVEL=1 -> clk=1 until 9 ns, falls 9, rises 11, falls 13.
REQ-033 Clocking a 64-bit load register (load 24 at 20..30 ns) -> register output 24 after the 25 ns rising edge, cycle_count=3 at 26 ns.

Source files
------------

// File: rtl/sim_clk_pkg.sv
// Shared timing defaults for the simulation clock source.
`timescale 1ns / 100ps
package sim_clk_pkg;

    localparam int DEFAULT_HALF_PERIOD = 5;
    localparam int DEFAULT_DIV_N       = 2;

endpackage

// File: rtl/clock_divider.sv
// Even-ratio 50 % duty divider, phase counted from reset release.
`timescale 1ns / 100ps
module clock_divider
    import sim_clk_pkg::*;
#(
    parameter int DIV_N = DEFAULT_DIV_N
) (
    input  logic clk,
    input  logic rst,
    output logic clk_div
);

    localparam int HALF = DIV_N / 2;

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            clk_div <= 1'b0;
        end else if (cnt == 8'(HALF - 1)) begin
            cnt     <= '0;
            clk_div <= ~clk_div;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/clock.sv
// Delay-based free-running clock source for simulation benches,
// with run enable, async reset, divided clock and edge counter.
`timescale 1ns / 100ps
module clock
    import sim_clk_pkg::*;
#(
    parameter int   HALF_PERIOD = DEFAULT_HALF_PERIOD,
    parameter int   START_DELAY = 0,
    parameter logic INIT_LEVEL  = 1'b0,
    parameter int   DIV_N       = DEFAULT_DIV_N
) (
    output logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        clk_div,
    output logic [63:0] cycle_count
);

    if (HALF_PERIOD < 1 || HALF_PERIOD > 1_000_000) begin : g_bad_hp
        $fatal(1, "clock: HALF_PERIOD must be 1..1000000");
    end
    if (START_DELAY < 0) begin : g_bad_sd
        $fatal(1, "clock: START_DELAY must be >= 0");
    end
    if (DIV_N < 2 || DIV_N > 256 || (DIV_N % 2) != 0) begin : g_bad_div
        $fatal(1, "clock: DIV_N must be even, 2..256");
    end

    logic        rst_i;
    logic        en_i;
    logic        irst;
    logic        clk_q;
    logic        por;
    logic        tick;
    logic        tick_p;
    logic        rst_p;
    logic        en_p;
    int unsigned tok;

    // Floating rst reads as idle, floating en reads as running.
    assign rst_i = (rst === 1'b1);
    assign en_i  = (en !== 1'b0);
    assign irst  = rst_i | por;
    assign clk   = clk_q;

    // A timer only fires if no restart/cancel bumped the token meanwhile.
    task automatic timer(input int unsigned k, input int unsigned d);
        #(d);
        if (k == tok)
            tick <= ~tick;
    endtask

    task automatic arm(input int unsigned d);
        tok = tok + 1;
        fork
            timer(tok, d);
        join_none
    endtask

    always begin : gen
        clk_q  <= INIT_LEVEL;
        por    <= 1'b1;
        tick   <= 1'b0;
        tick_p = 1'b0;
        tok    = 0;
        rst_p  = rst_i;
        en_p   = en_i;
        fork
            #0.1 por <= 1'b0;
        join_none
        if (!rst_i && en_i)
            arm(START_DELAY + HALF_PERIOD);
        forever begin
            @(tick or rst_i or en_i);
            if (rst_i) begin
                tok = tok + 1;
                clk_q <= INIT_LEVEL;
            end else if (rst_p) begin
                if (en_i)
                    arm(HALF_PERIOD);
            end else if (en_i != en_p) begin
                if (en_i)
                    arm(HALF_PERIOD);
                else
                    tok = tok + 1;
            end else if (tick != tick_p && en_i) begin
                clk_q <= ~clk_q;
                arm(HALF_PERIOD);
            end
            rst_p  = rst_i;
            en_p   = en_i;
            tick_p = tick;
        end
    end

    always_ff @(posedge clk_q or posedge irst) begin
        if (irst)
            cycle_count <= '0;
        else
            cycle_count <= cycle_count + 64'd1;
    end

    clock_divider #(
        .DIV_N(DIV_N)
    ) u_div (
        .clk    (clk_q),
        .rst    (irst),
        .clk_div(clk_div)
    );

endmodule

// File: tb/tb_clock.sv
// Bench for the simulation clock source: directed vector table per
// instance plus randomized en/rst traffic against a timeline model.
`timescale 1ns / 100ps
module tb_clock;

    typedef struct {
        int unsigned t;
        int unsigned dut;
        logic        rst;
        logic        en;
        logic        c;
        logic        d;
        logic [63:0] n;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic        clk0, clk1, clk2, clk3, clk4, clkr;
    logic        div0, div1, div2, div3, div4, divr;
    logic [63:0] cnt0, cnt1, cnt2, cnt3, cnt4, cntr;
    logic        rst1 = 1'b0, en1 = 1'b1;
    logic        rst2 = 1'b0, en2 = 1'b1;
    logic        rr   = 1'b0, er  = 1'b1;
    logic        load = 1'b0;
    logic [63:0] r64  = '0;

    clock u0 (.clk(clk0), .rst(1'b0), .en(1'b1),
              .clk_div(div0), .cycle_count(cnt0));
    clock u1 (.clk(clk1), .rst(rst1), .en(en1),
              .clk_div(div1), .cycle_count(cnt1));
    clock #(.INIT_LEVEL(1'b1)) u2 (.clk(clk2), .rst(rst2), .en(en2),
              .clk_div(div2), .cycle_count(cnt2));
    clock #(.DIV_N(4)) u3 (.clk(clk3), .rst(1'b0), .en(1'b1),
              .clk_div(div3), .cycle_count(cnt3));
    clock #(.HALF_PERIOD(2), .START_DELAY(7), .INIT_LEVEL(1'b1)) u4 (
              .clk(clk4), .rst(1'b0), .en(1'b1),
              .clk_div(div4), .cycle_count(cnt4));
    clock #(.HALF_PERIOD(3), .START_DELAY(2), .INIT_LEVEL(1'b1),
            .DIV_N(6)) ur (
              .clk(clkr), .rst(rr), .en(er),
              .clk_div(divr), .cycle_count(cntr));

    always_ff @(posedge clk0)
        if (load)
            r64 <= 64'd24;

    task automatic check(input string nm, input logic [65:0] act,
                         input logic [65:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [65:0] probe(input int unsigned d);
        case (d)
            0: return {clk0, div0, cnt0};
            1: return {clk1, div1, cnt1};
            2: return {clk2, div2, cnt2};
            3: return {clk3, div3, cnt3};
            default: return {clk4, div4, cnt4};
        endcase
    endfunction

    // t in 100 ps ticks; rst/en are driven right after the sample.
    function automatic void add(int unsigned t, int unsigned d,
                                logic r, logic e, logic c, logic v,
                                int unsigned n);
        vec_t x;
        x.t = t; x.dut = d; x.rst = r; x.en = e;
        x.c = c; x.d = v; x.n = 64'(n);
        vecs.push_back(x);
    endfunction

    task automatic run_dut(input int unsigned d);
        int unsigned now = 0;
        foreach (vecs[i]) begin
            if (vecs[i].dut == d) begin
                #(real'(vecs[i].t - now) * 0.1);
                now = vecs[i].t;
                check($sformatf("vec u%0d @%0d", d, now), probe(d),
                      {vecs[i].c, vecs[i].d, vecs[i].n});
                case (d)
                    1: begin rst1 = vecs[i].rst; en1 = vecs[i].en; end
                    2: begin rst2 = vecs[i].rst; en2 = vecs[i].en; end
                    default: ;
                endcase
            end
        end
    endtask

    task automatic run_reg();
        #20.0 load = 1'b1;
        #4.0  check("reg before edge", {2'b0, r64}, 66'd0);
        #2.0  check("reg after edge", {2'b0, r64}, 66'd24);
              check("count at 26", {2'b0, cnt0}, 66'd3);
        #4.0  load = 1'b0;
    endtask

    // Timeline model: next toggle deadline in ticks, level, edges since reset.
    task automatic run_rand();
        int unsigned now  = 0;
        int unsigned dl   = 50;
        bit          dl_v = 1'b1;
        bit          lvl  = 1'b1;
        longint unsigned cnt = 0;
        bit          m_rst = 1'b0;
        bit          m_en  = 1'b1;
        for (int i = 0; i < 80; i++) begin
            int unsigned t = now + $urandom_range(1, 80);
            int unsigned a = $urandom_range(0, 9);
            bit          dv;
            if (dl_v && t == dl)
                t++;
            #(real'(t - now) * 0.1);
            now = t;
            while (dl_v && dl < t) begin
                lvl = ~lvl;
                if (lvl)
                    cnt++;
                dl += 30;
            end
            dv = ((cnt / 3) % 2) == 1;
            check($sformatf("rand @%0d", now), {clkr, divr, cntr},
                  {lvl, dv, cnt});
            if (a < 2) begin
                m_rst = ~m_rst;
                rr = m_rst;
                if (m_rst) begin
                    lvl = 1'b1; cnt = 0; dl_v = 1'b0;
                end else begin
                    dl_v = m_en; dl = t + 30;
                end
            end else if (a < 5) begin
                m_en = ~m_en;
                er = m_en;
                if (!m_rst) begin
                    dl_v = m_en; dl = t + 30;
                end
            end
        end
    endtask

    initial begin
        add(2, 0, 0, 1, 0, 0, 0);    add(52, 0, 0, 1, 1, 1, 1);
        add(102, 0, 0, 1, 0, 1, 1);  add(152, 0, 0, 1, 1, 0, 2);
        add(252, 0, 0, 1, 1, 1, 3);  add(260, 0, 0, 1, 1, 1, 3);
        add(352, 0, 0, 1, 1, 0, 4);  add(452, 0, 0, 1, 1, 1, 5);
        add(460, 0, 0, 1, 1, 1, 5);  add(502, 0, 0, 1, 0, 1, 5);

        add(310, 1, 0, 1, 0, 1, 3);  add(320, 1, 1, 1, 0, 1, 3);
        add(321, 1, 1, 1, 0, 0, 0);  add(350, 1, 0, 1, 0, 0, 0);
        add(399, 1, 0, 1, 0, 0, 0);  add(402, 1, 0, 1, 1, 1, 1);
        add(452, 1, 0, 1, 0, 1, 1);  add(502, 1, 0, 1, 1, 0, 2);
        add(520, 1, 1, 1, 1, 0, 2);  add(521, 1, 0, 1, 0, 0, 0);
        add(570, 1, 0, 1, 0, 0, 0);  add(573, 1, 0, 1, 1, 1, 1);
        add(600, 1, 0, 0, 1, 1, 1);  add(625, 1, 1, 0, 1, 1, 1);
        add(630, 1, 0, 0, 0, 0, 0);  add(700, 1, 0, 1, 0, 0, 0);
        add(749, 1, 0, 1, 0, 0, 0);  add(752, 1, 0, 1, 1, 1, 1);

        add(2, 2, 0, 1, 1, 0, 0);    add(52, 2, 0, 1, 0, 0, 0);
        add(102, 2, 0, 1, 1, 1, 1);  add(120, 2, 0, 0, 1, 1, 1);
        add(202, 2, 0, 0, 1, 1, 1);  add(300, 2, 0, 1, 1, 1, 1);
        add(349, 2, 0, 1, 1, 1, 1);  add(352, 2, 0, 1, 0, 1, 1);
        add(399, 2, 0, 1, 0, 1, 1);  add(402, 2, 0, 1, 1, 0, 2);
        add(410, 2, 0, 0, 1, 0, 2);  add(420, 2, 0, 1, 1, 0, 2);
        add(469, 2, 0, 1, 1, 0, 2);  add(472, 2, 0, 1, 0, 0, 2);

        add(149, 3, 0, 1, 0, 0, 1);  add(152, 3, 0, 1, 1, 1, 2);
        add(349, 3, 0, 1, 0, 1, 3);  add(352, 3, 0, 1, 1, 0, 4);
        add(552, 3, 0, 1, 1, 1, 6);

        add(89, 4, 0, 1, 1, 0, 0);   add(92, 4, 0, 1, 0, 0, 0);
        add(109, 4, 0, 1, 0, 0, 0);  add(112, 4, 0, 1, 1, 1, 1);
        add(132, 4, 0, 1, 0, 1, 1);

        fork
            run_dut(0);
            run_dut(1);
            run_dut(2);
            run_dut(3);
            run_dut(4);
            run_reg();
            run_rand();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000.0;
        $display("FAIL watchdog: run did not complete by 20000 ns");
        $fatal(1, "timeout");
    end

endmodule
